// File: rtl/mem_bus_arbiter.sv
// Memory port arbiter shared by icache and dcache, with load-tag ownership tracking.
// Optional performance counters are compiled in when MEM_ARB_PERF_EN is defined.
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int NUM_TAGS     = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  ic_command,
    input  logic [31:0] ic_addr,
    input  logic [1:0]  dc_command,
    input  logic [31:0] dc_addr,
    input  logic [63:0] dc_data,
    input  logic        ic_flush,
    input  logic [3:0]  mem2proc_response,
    input  logic [3:0]  mem2proc_tag,
    input  logic [63:0] mem2proc_data,
    output logic [1:0]  mem_command,
    output logic [31:0] mem_addr,
    output logic [63:0] mem_data,
    output logic [3:0]  ic_response,
    output logic [3:0]  dc_response,
    output logic [3:0]  ic_ret_tag,
    output logic [3:0]  dc_ret_tag,
    output logic [63:0] ret_data,
    output logic        orphan_ret
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0] perf_ic_grants,
    output logic [31:0] perf_dc_grants,
    output logic [31:0] perf_ic_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        BUS_NONE  = 2'h0,
        BUS_LOAD  = 2'h1,
        BUS_STORE = 2'h2
    } bus_cmd_e;

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic             ic_req, dc_req;
    logic             ic_grant, dc_grant;
    logic             accepted, accept_load;
    logic             ret_hit, ret_miss, overwrite;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;

    // Owner table, one bit per tag; bit 0 is never written because tag 0 means "no tag".
    logic [NUM_TAGS-1:0] valid_q, valid_d;
    logic [NUM_TAGS-1:0] owner_dc_q, owner_dc_d;
    logic [NUM_TAGS-1:0] live_q, live_d;

    assign ic_req = (ic_command != BUS_NONE);
    assign dc_req = (dc_command != BUS_NONE);

    // Dcache has priority until the icache has waited through STARVE_LIMIT dcache grants.
    assign dc_grant = dc_req && !(ic_req && (starve_cnt_q == CNT_W'(STARVE_LIMIT)));
    assign ic_grant = ic_req && !dc_grant;

    assign accepted    = (ic_grant || dc_grant) && (mem2proc_response != 4'd0);
    assign accept_load = accepted && ((ic_grant ? ic_command : dc_command) == BUS_LOAD);

    assign ret_hit  = (mem2proc_tag != 4'd0) && valid_q[mem2proc_tag];
    assign ret_miss = (mem2proc_tag != 4'd0) && !valid_q[mem2proc_tag];
    // A tag returning this very cycle is being freed, so reusing it is not a collision.
    assign overwrite = accepted && valid_q[mem2proc_response] &&
                       !(ret_hit && (mem2proc_tag == mem2proc_response));

    always_comb begin
        mem_command = BUS_NONE;
        ic_response = 4'd0;
        dc_response = 4'd0;
        ic_ret_tag  = 4'd0;
        dc_ret_tag  = 4'd0;
        orphan_ret  = 1'b0;
        if (!reset) begin
            if (ic_grant) begin
                mem_command = ic_command;
                ic_response = mem2proc_response;
            end else if (dc_grant) begin
                mem_command = dc_command;
                dc_response = mem2proc_response;
            end
            if (ret_hit && owner_dc_q[mem2proc_tag]) begin
                dc_ret_tag = mem2proc_tag;
            end else if (ret_hit && live_q[mem2proc_tag]) begin
                ic_ret_tag = mem2proc_tag;
            end
            orphan_ret = ret_miss || overwrite;
        end
    end

    assign mem_addr = dc_grant ? dc_addr : ic_addr;
    assign mem_data = dc_data;
    assign ret_data = mem2proc_data;

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (!ic_req || ic_grant) begin
            starve_cnt_d = '0;
        end else if (dc_grant && (starve_cnt_q != CNT_W'(STARVE_LIMIT))) begin
            starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: every table bit gets its hold value first, so no path through this block infers a latch.
    always_comb begin
        valid_d    = valid_q;
        owner_dc_d = owner_dc_q;
        live_d     = live_q;
        if (ic_flush) begin
            for (int i = 1; i < NUM_TAGS; i++) begin
                if (valid_q[i] && !owner_dc_q[i]) begin
                    live_d[i] = 1'b0;
                end
            end
        end
        if (ret_hit) begin
            valid_d[mem2proc_tag]    = 1'b0;
            owner_dc_d[mem2proc_tag] = 1'b0;
            live_d[mem2proc_tag]     = 1'b0;
        end
        // Applied last so a same-cycle return of this tag is overridden by the new owner.
        if (accept_load) begin
            valid_d[mem2proc_response]    = 1'b1;
            owner_dc_d[mem2proc_response] = dc_grant;
            live_d[mem2proc_response]     = dc_grant || !ic_flush;
        end
    end

    // NOTE: the owner table is reset, unlike a data RAM, because stale valid bits would misroute returns.
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt_q <= '0;
            valid_q      <= '0;
            owner_dc_q   <= '0;
            live_q       <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            valid_q      <= valid_d;
            owner_dc_q   <= owner_dc_d;
            live_q       <= live_d;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_ic_grants_q, perf_dc_grants_q, perf_ic_stall_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_ic_grants_q <= '0;
            perf_dc_grants_q <= '0;
            perf_ic_stall_q  <= '0;
        end else begin
            if (accepted && ic_grant) perf_ic_grants_q <= perf_ic_grants_q + 32'd1;
            if (accepted && dc_grant) perf_dc_grants_q <= perf_dc_grants_q + 32'd1;
            if (ic_req && !ic_grant)  perf_ic_stall_q  <= perf_ic_stall_q + 32'd1;
        end
    end

    assign perf_ic_grants       = perf_ic_grants_q;
    assign perf_dc_grants       = perf_dc_grants_q;
    assign perf_ic_stall_cycles = perf_ic_stall_q;
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scoreboard bench for mem_bus_arbiter: each step pushes its expected outputs,
// then pops and compares them once the combinational outputs have settled.
module tb_mem_bus_arbiter;

    localparam logic [1:0] NONE  = 2'h0;
    localparam logic [1:0] LOAD  = 2'h1;
    localparam logic [1:0] STORE = 2'h2;

    logic        clock;
    logic        reset;
    logic [1:0]  ic_command;
    logic [31:0] ic_addr;
    logic [1:0]  dc_command;
    logic [31:0] dc_addr;
    logic [63:0] dc_data;
    logic        ic_flush;
    logic [3:0]  mem2proc_response;
    logic [3:0]  mem2proc_tag;
    logic [63:0] mem2proc_data;
    logic [1:0]  mem_command;
    logic [31:0] mem_addr;
    logic [63:0] mem_data;
    logic [3:0]  ic_response;
    logic [3:0]  dc_response;
    logic [3:0]  ic_ret_tag;
    logic [3:0]  dc_ret_tag;
    logic [63:0] ret_data;
    logic        orphan_ret;

    mem_bus_arbiter #(.STARVE_LIMIT(4), .NUM_TAGS(16)) dut (
        .clock             (clock),
        .reset             (reset),
        .ic_command        (ic_command),
        .ic_addr           (ic_addr),
        .dc_command        (dc_command),
        .dc_addr           (dc_addr),
        .dc_data           (dc_data),
        .ic_flush          (ic_flush),
        .mem2proc_response (mem2proc_response),
        .mem2proc_tag      (mem2proc_tag),
        .mem2proc_data     (mem2proc_data),
        .mem_command       (mem_command),
        .mem_addr          (mem_addr),
        .mem_data          (mem_data),
        .ic_response       (ic_response),
        .dc_response       (dc_response),
        .ic_ret_tag        (ic_ret_tag),
        .dc_ret_tag        (dc_ret_tag),
        .ret_data          (ret_data),
        .orphan_ret        (orphan_ret)
    );

    typedef struct packed {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] mdata;
        logic [3:0]  icr;
        logic [3:0]  dcr;
        logic [3:0]  icrt;
        logic [3:0]  dcrt;
        logic        orph;
        logic [63:0] rdata;
    } exp_t;

    exp_t  sb_q[$];
    string name_q[$];
    int    tests  = 0;
    int    failed = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check_field(input string name, input string field,
                               input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s.%s observed=%0h expected=%0h", name, field, obs, exp);
        end
    endtask

    task automatic compare_head();
        exp_t  e;
        string n;
        tests++;
        assert (sb_q.size() != 0) else begin
            failed++;
            $error("FAIL scoreboard: observed=empty expected=entry");
        end
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n = name_q.pop_front();
            check_field(n, "mem_command", 64'(mem_command), 64'(e.cmd));
            check_field(n, "mem_addr",    64'(mem_addr),    64'(e.addr));
            check_field(n, "mem_data",    mem_data,         e.mdata);
            check_field(n, "ic_response", 64'(ic_response), 64'(e.icr));
            check_field(n, "dc_response", 64'(dc_response), 64'(e.dcr));
            check_field(n, "ic_ret_tag",  64'(ic_ret_tag),  64'(e.icrt));
            check_field(n, "dc_ret_tag",  64'(dc_ret_tag),  64'(e.dcrt));
            check_field(n, "orphan_ret",  64'(orphan_ret),  64'(e.orph));
            check_field(n, "ret_data",    ret_data,         e.rdata);
        end
    endtask

    // Drive one cycle of inputs, record the expected outputs, compare after settling,
    // then advance to just past the next rising edge.
    task automatic step(input string name,
                        input logic [1:0] icc, input logic [31:0] ica,
                        input logic [1:0] dcc, input logic [31:0] dca,
                        input logic [3:0] resp, input logic [3:0] rtag, input logic flush,
                        input logic [1:0] e_cmd, input logic [31:0] e_addr,
                        input logic [3:0] e_icr, input logic [3:0] e_dcr,
                        input logic [3:0] e_icrt, input logic [3:0] e_dcrt, input logic e_orph);
        exp_t e;
        ic_command        = icc;
        ic_addr           = ica;
        dc_command        = dcc;
        dc_addr           = dca;
        dc_data           = {32'hD00D_0000, dca};
        mem2proc_response = resp;
        mem2proc_tag      = rtag;
        mem2proc_data     = {60'hCAFE_0000_0000_000, rtag};
        ic_flush          = flush;
        e.cmd   = e_cmd;
        e.addr  = e_addr;
        e.mdata = {32'hD00D_0000, dca};
        e.icr   = e_icr;
        e.dcr   = e_dcr;
        e.icrt  = e_icrt;
        e.dcrt  = e_dcrt;
        e.orph  = e_orph;
        e.rdata = {60'hCAFE_0000_0000_000, rtag};
        sb_q.push_back(e);
        name_q.push_back(name);
        #1;
        compare_head();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        ic_command = NONE; ic_addr = '0; dc_command = NONE; dc_addr = '0; dc_data = '0;
        ic_flush = 1'b0; mem2proc_response = '0; mem2proc_tag = '0; mem2proc_data = '0;
        @(posedge clock);
        #1;

        // Outputs are forced quiet while reset is high even with a live request.
        step("reset", LOAD, 32'h100, NONE, 32'h0, 4'd3, 4'd0, 1'b0,
             NONE, 32'h100, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        reset = 1'b0;

        // Icache-only load, its return, and a repeated return of the freed tag.
        step("ic_load",    LOAD, 32'h100, NONE, 32'h0, 4'd3, 4'd0, 1'b0,
             LOAD, 32'h100, 4'd3, 4'd0, 4'd0, 4'd0, 1'b0);
        step("ic_ret3",    NONE, 32'h100, NONE, 32'h0, 4'd0, 4'd3, 1'b0,
             NONE, 32'h100, 4'd0, 4'd0, 4'd3, 4'd0, 1'b0);
        step("ic_ret3_again", NONE, 32'h100, NONE, 32'h0, 4'd0, 4'd3, 1'b0,
             NONE, 32'h100, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);

        // Both request every cycle: four dcache grants, then the icache, repeating.
        for (int i = 0; i < 10; i++) begin
            if (i % 5 == 4) begin
                step($sformatf("starve_%0d", i), LOAD, 32'h400, STORE, 32'h800,
                     (i == 4) ? 4'd12 : 4'd13, 4'd0, 1'b0,
                     LOAD, 32'h400, (i == 4) ? 4'd12 : 4'd13, 4'd0, 4'd0, 4'd0, 1'b0);
            end else begin
                step($sformatf("starve_%0d", i), LOAD, 32'h400, STORE, 32'h800, 4'd1, 4'd0, 1'b0,
                     STORE, 32'h800, 4'd0, 4'd1, 4'd0, 4'd0, 1'b0);
            end
        end

        // An idle icache cycle clears the starvation count, so four fresh dcache grants follow.
        for (int j = 0; j < 9; j++) begin
            if (j == 3) begin
                step($sformatf("idle_clr_%0d", j), NONE, 32'h400, STORE, 32'h800, 4'd1, 4'd0, 1'b0,
                     STORE, 32'h800, 4'd0, 4'd1, 4'd0, 4'd0, 1'b0);
            end else if (j == 8) begin
                step($sformatf("idle_clr_%0d", j), LOAD, 32'h400, STORE, 32'h800, 4'd14, 4'd0, 1'b0,
                     LOAD, 32'h400, 4'd14, 4'd0, 4'd0, 4'd0, 1'b0);
            end else begin
                step($sformatf("idle_clr_%0d", j), LOAD, 32'h400, STORE, 32'h800, 4'd1, 4'd0, 1'b0,
                     STORE, 32'h800, 4'd0, 4'd1, 4'd0, 4'd0, 1'b0);
            end
        end

        // Returns for the icache loads granted by the fairness rule.
        step("ret12", NONE, 32'h0, NONE, 32'h0, 4'd0, 4'd12, 1'b0,
             NONE, 32'h0, 4'd0, 4'd0, 4'd12, 4'd0, 1'b0);
        step("ret13", NONE, 32'h0, NONE, 32'h0, 4'd0, 4'd13, 1'b0,
             NONE, 32'h0, 4'd0, 4'd0, 4'd13, 4'd0, 1'b0);
        step("ret14", NONE, 32'h0, NONE, 32'h0, 4'd0, 4'd14, 1'b0,
             NONE, 32'h0, 4'd0, 4'd0, 4'd14, 4'd0, 1'b0);

        // A store leaves no owner entry, so its tag coming back is an orphan.
        step("dc_store5", NONE, 32'h0, STORE, 32'h300, 4'd5, 4'd0, 1'b0,
             STORE, 32'h300, 4'd0, 4'd5, 4'd0, 4'd0, 1'b0);
        step("store_ret5", NONE, 32'h0, NONE, 32'h0, 4'd0, 4'd5, 1'b0,
             NONE, 32'h0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);

        // Flush kills icache entries (including one accepted in the flush cycle), not dcache ones.
        step("dc_load6", NONE, 32'h0, LOAD, 32'h600, 4'd6, 4'd0, 1'b0,
             LOAD, 32'h600, 4'd0, 4'd6, 4'd0, 4'd0, 1'b0);
        step("ic_load7", LOAD, 32'h500, NONE, 32'h0, 4'd7, 4'd0, 1'b0,
             LOAD, 32'h500, 4'd7, 4'd0, 4'd0, 4'd0, 1'b0);
        step("ic_load8_flush", LOAD, 32'h508, NONE, 32'h0, 4'd8, 4'd0, 1'b1,
             LOAD, 32'h508, 4'd8, 4'd0, 4'd0, 4'd0, 1'b0);
        step("dead_ret7", NONE, 32'h0, NONE, 32'h0, 4'd0, 4'd7, 1'b0,
             NONE, 32'h0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        step("dead_ret8", NONE, 32'h0, NONE, 32'h0, 4'd0, 4'd8, 1'b0,
             NONE, 32'h0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        step("dc_ret6", NONE, 32'h0, NONE, 32'h0, 4'd0, 4'd6, 1'b0,
             NONE, 32'h0, 4'd0, 4'd0, 4'd0, 4'd6, 1'b0);
        step("freed_ret7", NONE, 32'h0, NONE, 32'h0, 4'd0, 4'd7, 1'b0,
             NONE, 32'h0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);

        // Same tag returned to dcache and reallocated to icache in one cycle.
        step("dc_load2", NONE, 32'h0, LOAD, 32'h620, 4'd2, 4'd0, 1'b0,
             LOAD, 32'h620, 4'd0, 4'd2, 4'd0, 4'd0, 1'b0);
        step("swap2", LOAD, 32'h600, NONE, 32'h0, 4'd2, 4'd2, 1'b0,
             LOAD, 32'h600, 4'd2, 4'd0, 4'd0, 4'd2, 1'b0);
        step("ic_ret2", NONE, 32'h0, NONE, 32'h0, 4'd0, 4'd2, 1'b0,
             NONE, 32'h0, 4'd0, 4'd0, 4'd2, 4'd0, 1'b0);

        // Rejected dcache load is held by the requester and accepted on retry.
        step("dc_reject", NONE, 32'h0, LOAD, 32'h700, 4'd0, 4'd0, 1'b0,
             LOAD, 32'h700, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        step("dc_retry9", NONE, 32'h0, LOAD, 32'h700, 4'd9, 4'd0, 1'b0,
             LOAD, 32'h700, 4'd0, 4'd9, 4'd0, 4'd0, 1'b0);
        step("dc_ret9", NONE, 32'h0, NONE, 32'h0, 4'd0, 4'd9, 1'b0,
             NONE, 32'h0, 4'd0, 4'd0, 4'd0, 4'd9, 1'b0);

        // Accepting a tag that is still outstanding overwrites the owner and pulses orphan_ret.
        step("ic_load4", LOAD, 32'h140, NONE, 32'h0, 4'd4, 4'd0, 1'b0,
             LOAD, 32'h140, 4'd4, 4'd0, 4'd0, 4'd0, 1'b0);
        step("dc_dup4", NONE, 32'h0, LOAD, 32'h740, 4'd4, 4'd0, 1'b0,
             LOAD, 32'h740, 4'd0, 4'd4, 4'd0, 4'd0, 1'b1);
        step("dc_ret4", NONE, 32'h0, NONE, 32'h0, 4'd0, 4'd4, 1'b0,
             NONE, 32'h0, 4'd0, 4'd0, 4'd0, 4'd4, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
